// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - program counter / fetch sequencer with writable branch-target table
// Optional RUN-cycle counter on CycleCnt when FETCH_CYCLE_CNT_EN is defined.
module fetch_unit #(
  parameter int PC_W      = 10,
  parameter int LUT_IDX_W = 5
) (
  input  logic                 Clk,
  input  logic                 Reset,
  input  logic                 Start,
  input  logic                 BranchEn,
  input  logic                 Zero,
  input  logic                 Ack,
  input  logic [LUT_IDX_W-1:0] TargIdx,
  input  logic                 LutWrEn,
  input  logic [LUT_IDX_W-1:0] LutWrIdx,
  input  logic [PC_W-1:0]      LutWrData,
  output logic [PC_W-1:0]      ProgCtr,
  output logic                 Running,
`ifdef FETCH_CYCLE_CNT_EN
  output logic                 Done,
  output logic [15:0]          CycleCnt
`else
  output logic                 Done
`endif
);

  localparam int LUT_DEPTH = 2 ** LUT_IDX_W;
  localparam logic [PC_W-1:0] PC_ONE = 1;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] HALT = 2'd2;

  logic [1:0]      state;
  logic [PC_W-1:0] lut [LUT_DEPTH];

  assign Running = (state == RUN);
  assign Done    = (state == HALT);

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state   <= IDLE;
      ProgCtr <= '0;
    end else begin
      case (state)
        IDLE: begin
          ProgCtr <= '0;
          if (Start) state <= RUN;
        end
        RUN: begin
          // Halt takes priority over a taken branch; PC stays on the halt instruction.
          if (Ack) begin
            state <= HALT;
          end else if (BranchEn && Zero) begin
            ProgCtr <= lut[TargIdx];
          end else begin
            ProgCtr <= ProgCtr + PC_ONE;
          end
        end
        HALT: begin
          if (Start) begin
            state   <= RUN;
            ProgCtr <= '0;
          end
        end
        default: begin
          state   <= IDLE;
          ProgCtr <= '0;
        end
      endcase
    end
  end

  // Branch read above sees the pre-edge entry, so a same-cycle write is visible next cycle.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      for (int i = 0; i < LUT_DEPTH; i++) lut[i] <= '0;
    end else if (LutWrEn) begin
      lut[LutWrIdx] <= LutWrData;
    end
  end

`ifdef FETCH_CYCLE_CNT_EN
  always_ff @(posedge Clk) begin
    if (Reset) begin
      CycleCnt <= '0;
    end else if (state == RUN) begin
      if (CycleCnt != 16'hFFFF) CycleCnt <= CycleCnt + 16'd1;
    end else if (Start) begin
      CycleCnt <= '0;
    end
  end
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - table-driven self-checking bench for fetch_unit
module tb_fetch_unit;

  logic       Clk = 1'b0;
  logic       Reset, Start, BranchEn, Zero, Ack, LutWrEn;
  logic [4:0] TargIdx, LutWrIdx;
  logic [9:0] LutWrData;
  logic [9:0] ProgCtr;
  logic       Running, Done;
`ifdef FETCH_CYCLE_CNT_EN
  logic [15:0] CycleCnt;
`endif

  int checks = 0;
  int fails  = 0;

  always #5 Clk = ~Clk;

  fetch_unit #(.PC_W(10), .LUT_IDX_W(5)) dut (
    .Clk(Clk), .Reset(Reset), .Start(Start), .BranchEn(BranchEn), .Zero(Zero), .Ack(Ack),
    .TargIdx(TargIdx), .LutWrEn(LutWrEn), .LutWrIdx(LutWrIdx), .LutWrData(LutWrData),
    .ProgCtr(ProgCtr), .Running(Running),
`ifdef FETCH_CYCLE_CNT_EN
    .Done(Done), .CycleCnt(CycleCnt)
`else
    .Done(Done)
`endif
  );

  typedef struct {
    logic        rst, start, br, zero, ack;
    logic [4:0]  idx;
    logic        wen;
    logic [4:0]  widx;
    logic [9:0]  wdata;
    logic [9:0]  exp_pc;
    logic        exp_run, exp_done;
    logic [15:0] exp_cnt;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic rst, start, br, zero, ack, input logic [4:0] idx,
                     input logic wen, input logic [4:0] widx, input logic [9:0] wdata,
                     input logic [9:0] pc, input logic run, done, input logic [15:0] cnt);
    vec_t v;
    v.rst = rst; v.start = start; v.br = br; v.zero = zero; v.ack = ack; v.idx = idx;
    v.wen = wen; v.widx = widx; v.wdata = wdata;
    v.exp_pc = pc; v.exp_run = run; v.exp_done = done; v.exp_cnt = cnt;
    vecs.push_back(v);
  endtask

  task automatic check(input string name, input int step, input logic [31:0] act, exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s step %0d: got %0h expected %0h", name, step, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    Reset = v.rst; Start = v.start; BranchEn = v.br; Zero = v.zero; Ack = v.ack;
    TargIdx = v.idx; LutWrEn = v.wen; LutWrIdx = v.widx; LutWrData = v.wdata;
  endtask

  task automatic check_outputs(input int step, input logic [9:0] pc, input logic run, done,
                               input logic [15:0] cnt);
    check("pc", step, 32'(ProgCtr), 32'(pc));
    check("running", step, 32'(Running), 32'(run));
    check("done", step, 32'(Done), 32'(done));
    check("exclusive", step, 32'(Running & Done), 32'd0);
`ifdef FETCH_CYCLE_CNT_EN
    check("cyclecnt", step, 32'(CycleCnt), 32'(cnt));
`else
    if (cnt == 16'hFFFF) $display("unreachable sentinel");
`endif
  endtask

  initial begin
    vec_t idle_v;
    // rst start br zero ack idx  wen widx wdata   pc     run done cnt
    add(1, 0, 0, 0, 0, 0,  0, 0, 0,      10'h000, 0, 0, 0);
    add(0, 0, 0, 0, 0, 0,  0, 0, 0,      10'h000, 0, 0, 0);
    add(0, 1, 0, 0, 0, 0,  0, 0, 0,      10'h000, 1, 0, 0);
    add(0, 0, 0, 0, 0, 0,  0, 0, 0,      10'h001, 1, 0, 1);
    add(0, 0, 0, 0, 0, 0,  0, 0, 0,      10'h002, 1, 0, 2);
    add(0, 0, 0, 0, 0, 0,  0, 0, 0,      10'h003, 1, 0, 3);
    add(0, 0, 0, 0, 0, 0,  1, 3, 10'h155, 10'h004, 1, 0, 4);
    add(0, 0, 1, 1, 0, 3,  0, 0, 0,      10'h155, 1, 0, 5);
    add(0, 0, 1, 0, 0, 3,  0, 0, 0,      10'h156, 1, 0, 6);
    add(0, 0, 0, 0, 0, 0,  1, 2, 10'd5,  10'h157, 1, 0, 7);
    add(0, 0, 1, 1, 0, 2,  1, 2, 10'd20, 10'd5,   1, 0, 8);
    add(0, 0, 1, 1, 0, 2,  0, 0, 0,      10'd20,  1, 0, 9);
    add(0, 0, 0, 0, 0, 0,  1, 4, 10'd7,  10'd21,  1, 0, 10);
    add(0, 0, 1, 1, 0, 4,  0, 0, 0,      10'd7,   1, 0, 11);
    add(0, 0, 1, 1, 1, 3,  0, 0, 0,      10'd7,   0, 1, 12);
    add(0, 0, 0, 0, 0, 0,  0, 0, 0,      10'd7,   0, 1, 12);
    add(0, 1, 1, 1, 0, 3,  0, 0, 0,      10'd0,   1, 0, 0);
    add(0, 0, 0, 0, 1, 0,  0, 0, 0,      10'd0,   0, 1, 1);
    add(0, 1, 0, 0, 0, 0,  0, 0, 0,      10'd0,   1, 0, 0);
    add(0, 0, 0, 0, 0, 0,  1, 5, 10'h3FF, 10'd1,  1, 0, 1);
    add(0, 0, 1, 1, 0, 5,  0, 0, 0,      10'h3FF, 1, 0, 2);
    add(0, 0, 0, 0, 0, 0,  0, 0, 0,      10'h000, 1, 0, 3);
    add(0, 1, 0, 0, 0, 0,  0, 0, 0,      10'h001, 1, 0, 4);
    add(0, 0, 0, 0, 0, 0,  1, 6, 10'd40, 10'd2,   1, 0, 5);
    add(0, 0, 1, 1, 0, 6,  0, 0, 0,      10'd40,  1, 0, 6);
    add(1, 1, 1, 1, 0, 6,  1, 7, 10'd9,  10'd0,   0, 0, 0);
    add(0, 0, 0, 0, 0, 0,  0, 0, 0,      10'd0,   0, 0, 0);
    add(0, 1, 0, 0, 0, 0,  0, 0, 0,      10'd0,   1, 0, 0);
    add(0, 0, 1, 1, 0, 3,  0, 0, 0,      10'd0,   1, 0, 1);
    add(0, 0, 1, 1, 0, 7,  0, 0, 0,      10'd0,   1, 0, 2);
    add(0, 0, 0, 0, 1, 0,  0, 0, 0,      10'd0,   0, 1, 3);

    idle_v = vecs[1];
    drive(idle_v);
    @(negedge Clk);
    foreach (vecs[i]) begin
      drive(vecs[i]);
      @(posedge Clk);
      #1;
      check_outputs(i, vecs[i].exp_pc, vecs[i].exp_run, vecs[i].exp_done, vecs[i].exp_cnt);
      @(negedge Clk);
    end

    // Multi-cycle: reset held across Start, then Zero without BranchEn counts sequentially.
    Reset = 1; Start = 1; BranchEn = 0; Zero = 1; Ack = 0; TargIdx = 5'd3; LutWrEn = 0;
    repeat (3) @(posedge Clk);
    #1;
    check_outputs(100, 10'd0, 0, 0, 16'd0);
    @(negedge Clk);
    Reset = 0;
    @(posedge Clk); #1;
    check_outputs(101, 10'd0, 1, 0, 16'd0);
    @(negedge Clk);
    Start = 0;
    repeat (3) @(posedge Clk);
    #1;
    check_outputs(102, 10'd3, 1, 0, 16'd3);
    @(negedge Clk);
    Ack = 1; Start = 1;
    @(posedge Clk); #1;
    check_outputs(103, 10'd3, 0, 1, 16'd4);
    @(negedge Clk);
    Ack = 0; Start = 0;
    repeat (4) @(posedge Clk);
    #1;
    check_outputs(104, 10'd3, 0, 1, 16'd4);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
